// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller for the SLC-3 operate instructions (ADD/AND/NOT).
// Latches an instruction on start, then steps DECODE -> EXEC -> WB (or ERR) driving datapath controls.
module alu_op_sequencer #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               start,
  input  logic [15:0]        IR_in,
  output logic               ready,
  output logic [2:0]         SR1,
  output logic [2:0]         SR2,
  output logic [2:0]         DR,
  output logic               SR2MUX_sel,
  output logic [15:0]        SEXT_5,
  output logic [1:0]         ALUK,
  output logic               LD_REG,
  output logic               LD_CC,
  output logic               done,
  output logic               illegal,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_ERR
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  state_t             state_q;
  logic [15:0]        ir_q;
  logic [COUNT_W-1:0] cnt_q;
  logic [3:0]         opcode;
  logic               op_legal;

  function automatic logic is_legal(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  endfunction

  function automatic logic [1:0] aluk_of(input logic [3:0] op);
    case (op)
      OP_AND:  return 2'b01;
      OP_NOT:  return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  assign opcode   = ir_q[15:12];
  assign op_legal = is_legal(opcode);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            ir_q    <= IR_in;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: state_q <= op_legal ? S_EXEC : S_ERR;
        S_EXEC:   state_q <= S_WB;
        S_WB: begin
          cnt_q   <= cnt_q + COUNT_W'(1);
          state_q <= S_IDLE;
        end
        S_ERR:    state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // Moore decode: outputs depend only on state_q and ir_q.
  always_comb begin
    ready       = (state_q == S_IDLE);
    SR1         = 3'd0;
    SR2         = 3'd0;
    DR          = 3'd0;
    SR2MUX_sel  = 1'b0;
    SEXT_5      = 16'd0;
    ALUK        = 2'b00;
    LD_REG      = (state_q == S_WB);
    LD_CC       = (state_q == S_WB);
    done        = (state_q == S_WB);
    illegal     = (state_q == S_ERR);
    instr_count = cnt_q;
    if (state_q == S_DECODE || state_q == S_EXEC || state_q == S_WB) begin
      DR     = ir_q[11:9];
      SR1    = ir_q[8:6];
      SR2    = ir_q[2:0];
      SEXT_5 = {{11{ir_q[4]}}, ir_q[4:0]};
      if (op_legal) begin
        ALUK       = aluk_of(opcode);
        SR2MUX_sel = (opcode != OP_NOT) && ir_q[5];
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed scenarios plus randomized traffic against a timeline model.
module tb_alu_op_sequencer;

  localparam int CW = 4;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          start;
  logic [15:0]   IR_in;
  logic          ready;
  logic [2:0]    SR1, SR2, DR;
  logic          SR2MUX_sel;
  logic [15:0]   SEXT_5;
  logic [1:0]    ALUK;
  logic          LD_REG, LD_CC, done, illegal;
  logic [CW-1:0] instr_count;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: whether an instruction is in flight, cycles since it was accepted, its word, retired count.
  bit          m_busy;
  int          m_off;
  logic [15:0] m_ir;
  int          m_cnt;

  alu_op_sequencer #(.COUNT_W(CW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .IR_in(IR_in),
    .ready(ready), .SR1(SR1), .SR2(SR2), .DR(DR), .SR2MUX_sel(SR2MUX_sel),
    .SEXT_5(SEXT_5), .ALUK(ALUK), .LD_REG(LD_REG), .LD_CC(LD_CC),
    .done(done), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal_op(input logic [3:0] op);
    return op == 4'd1 || op == 4'd5 || op == 4'd9;
  endfunction

  task automatic model_edge();
    if (!Reset_n) begin
      m_busy = 0; m_off = 0; m_ir = '0; m_cnt = 0;
    end else if (m_busy) begin
      m_off++;
      if (legal_op(m_ir[15:12])) begin
        if (m_off == 4) begin
          m_busy = 0;
          m_cnt  = (m_cnt + 1) % (1 << CW);
        end
      end else if (m_off == 3) begin
        m_busy = 0;
      end
    end else if (start) begin
      m_busy = 1; m_off = 1; m_ir = IR_in;
    end
  endtask

  task automatic compare_all();
    bit         lg;
    logic [3:0] op;
    logic [1:0] ak;
    op = m_ir[15:12];
    lg = m_busy && legal_op(op);
    ak = (op == 4'd5) ? 2'b01 : (op == 4'd9) ? 2'b10 : 2'b00;
    chk("ready",   32'(ready),   32'(!m_busy));
    chk("LD_REG",  32'(LD_REG),  32'(lg && m_off == 3));
    chk("LD_CC",   32'(LD_CC),   32'(lg && m_off == 3));
    chk("done",    32'(done),    32'(lg && m_off == 3));
    chk("illegal", 32'(illegal), 32'(m_busy && !lg && m_off == 2));
    chk("count",   32'(instr_count), 32'(m_cnt));
    if (!m_busy) begin
      chk("idle_DR",   32'(DR), 0);
      chk("idle_SR1",  32'(SR1), 0);
      chk("idle_SR2",  32'(SR2), 0);
      chk("idle_SEXT", 32'(SEXT_5), 0);
      chk("idle_ALUK", 32'(ALUK), 0);
      chk("idle_sel",  32'(SR2MUX_sel), 0);
    end else if (m_off == 1 || lg) begin
      chk("DR",   32'(DR),  32'(m_ir[11:9]));
      chk("SR1",  32'(SR1), 32'(m_ir[8:6]));
      chk("SR2",  32'(SR2), 32'(m_ir[2:0]));
      chk("SEXT", 32'(SEXT_5), 32'($signed(m_ir[4:0])) & 32'hFFFF);
      if (lg) begin
        chk("ALUK", 32'(ALUK), 32'(ak));
        chk("sel",  32'(SR2MUX_sel), 32'(op != 4'd9 && m_ir[5]));
      end
    end else begin
      chk("err_ALUK", 32'(ALUK), 0);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    compare_all();
  endtask

  task automatic issue(input logic [15:0] ir);
    start = 1'b1;
    IR_in = ir;
    tick();
    start = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b0; start = 1'b0; IR_in = '0;
    m_busy = 0; m_off = 0; m_ir = '0; m_cnt = 0;
    tick(); tick();
    chk("rst_ready", 32'(ready), 1);
    chk("rst_count", 32'(instr_count), 0);
    Reset_n = 1'b1;

    // ADD R1,R2,R3
    issue(16'h1283);
    chk("add_DR", 32'(DR), 1);
    chk("add_SR1", 32'(SR1), 2);
    chk("add_SR2", 32'(SR2), 3);
    chk("add_sel", 32'(SR2MUX_sel), 0);
    tick(); tick();
    chk("add_LD_REG", 32'(LD_REG), 1);
    chk("add_done", 32'(done), 1);
    tick();
    chk("add_ready", 32'(ready), 1);
    chk("add_count", 32'(instr_count), 1);

    // AND R3,R2,#-1
    issue(16'h56BF);
    chk("and_sel", 32'(SR2MUX_sel), 1);
    chk("and_SEXT", 32'(SEXT_5), 32'hFFFF);
    chk("and_ALUK", 32'(ALUK), 1);
    tick(); tick(); tick();

    // NOT R3,R1
    issue(16'h967F);
    chk("not_ALUK", 32'(ALUK), 2);
    chk("not_sel", 32'(SR2MUX_sel), 0);
    tick(); tick(); tick();

    // LD is not supported
    issue(16'h2000);
    tick();
    chk("ld_illegal", 32'(illegal), 1);
    chk("ld_LD_REG", 32'(LD_REG), 0);
    chk("ld_LD_CC", 32'(LD_CC), 0);
    tick();
    chk("ld_ready", 32'(ready), 1);
    chk("ld_count", 32'(instr_count), 3);

    // start held through the sequence with a different word
    start = 1'b1; IR_in = 16'h1283;
    tick();
    IR_in = 16'h5A81;
    tick();
    chk("hold_DR", 32'(DR), 1);
    chk("hold_ALUK", 32'(ALUK), 0);
    tick();
    chk("hold_SR1", 32'(SR1), 2);
    start = 1'b0;
    tick();

    // reset while in EXEC
    issue(16'h1283);
    tick();
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    chk("rexec_LD_REG", 32'(LD_REG), 0);
    chk("rexec_ready", 32'(ready), 1);
    chk("rexec_count", 32'(instr_count), 0);

    // 16 retirements wrap a 4-bit count back to zero
    for (int i = 0; i < 16; i++) begin
      issue(16'h1283);
      tick(); tick(); tick();
      if (i == 14) chk("wrap_15", 32'(instr_count), 15);
    end
    chk("wrap_0", 32'(instr_count), 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [3:0] op;
      int r;
      Reset_n = ($urandom_range(0, 63) != 0);
      start   = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 3);
      op = (r == 0) ? 4'd1 : (r == 1) ? 4'd5 : (r == 2) ? 4'd9 : 4'($urandom);
      IR_in = {op, 12'($urandom)};
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
